// File: rtl/move_scheduler.sv
// move_scheduler: turns key presses into per-player queued moves, issued round-robin
// over valid/ready with a fixed cooldown gap after every accepted move.
module move_scheduler #(
    parameter int DEPTH    = 4,
    parameter int COOLDOWN = 16,
    parameter int CD_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    game_enable,
    input  logic                    key_signal,
    input  logic [3:0]              key_cmd,
    input  logic                    key_player,
    input  logic                    move_ready,
    output logic                    move_valid,
    output logic [3:0]              move_cmd,
    output logic                    move_player,
    output logic [$clog2(DEPTH):0]  pending0,
    output logic [$clog2(DEPTH):0]  pending1,
    output logic [1:0]              overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;
    state_t          state_q;
    logic            sig_q, lg_q;
    logic [3:0]      mem0_q [DEPTH];
    logic [3:0]      mem1_q [DEPTH];
    logic [AW:0]     wp0_q, rp0_q, wp1_q, rp1_q;
    logic [CD_W-1:0] cnt_q;
    logic            press, empty0, empty1, full0, full1, gnt, pop0, pop1, push0, push1;

    assign press  = key_signal && !sig_q && key_cmd != 4'd0 && game_enable;
    assign empty0 = wp0_q == rp0_q;
    assign empty1 = wp1_q == rp1_q;
    assign full0  = (wp0_q[AW] != rp0_q[AW]) && (wp0_q[AW-1:0] == rp0_q[AW-1:0]);
    assign full1  = (wp1_q[AW] != rp1_q[AW]) && (wp1_q[AW-1:0] == rp1_q[AW-1:0]);
    // On a tie the player that did not win last time is granted
    assign gnt    = empty0 ? 1'b1 : empty1 ? 1'b0 : !lg_q;
    assign pop0   = state_q == IDLE && !empty0 && !gnt;
    assign pop1   = state_q == IDLE && !empty1 && gnt;
    assign push0  = press && !key_player && (!full0 || pop0);
    assign push1  = press && key_player && (!full1 || pop1);
    assign pending0 = wp0_q - rp0_q;
    assign pending1 = wp1_q - rp1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sig_q       <= 1'b1;
            lg_q        <= 1'b1;
            wp0_q       <= '0;
            rp0_q       <= '0;
            wp1_q       <= '0;
            rp1_q       <= '0;
            cnt_q       <= '0;
            move_valid  <= 1'b0;
            move_cmd    <= 4'd0;
            move_player <= 1'b0;
            overflow    <= 2'b00;
        end else begin
            sig_q <= key_signal;
            if (!game_enable) begin
                state_q    <= IDLE;
                wp0_q      <= '0;
                rp0_q      <= '0;
                wp1_q      <= '0;
                rp1_q      <= '0;
                cnt_q      <= '0;
                move_valid <= 1'b0;
                overflow   <= 2'b00;
            end else begin
                if (push0) begin
                    mem0_q[wp0_q[AW-1:0]] <= key_cmd;
                    wp0_q <= wp0_q + (AW+1)'(1);
                end
                if (push1) begin
                    mem1_q[wp1_q[AW-1:0]] <= key_cmd;
                    wp1_q <= wp1_q + (AW+1)'(1);
                end
                if (press && !key_player && full0 && !pop0) overflow[0] <= 1'b1;
                if (press && key_player && full1 && !pop1) overflow[1] <= 1'b1;
                if (pop0) rp0_q <= rp0_q + (AW+1)'(1);
                if (pop1) rp1_q <= rp1_q + (AW+1)'(1);
                case (state_q)
                    IDLE: if (!empty0 || !empty1) begin
                        move_cmd    <= gnt ? mem1_q[rp1_q[AW-1:0]] : mem0_q[rp0_q[AW-1:0]];
                        move_player <= gnt;
                        move_valid  <= 1'b1;
                        lg_q        <= gnt;
                        state_q     <= ISSUE;
                    end
                    ISSUE: if (move_ready) begin
                        move_valid <= 1'b0;
                        if (COOLDOWN == 0) state_q <= IDLE;
                        else begin
                            cnt_q   <= CD_W'(COOLDOWN);
                            state_q <= COOL;
                        end
                    end
                    COOL: begin
                        cnt_q <= cnt_q - CD_W'(1);
                        if (cnt_q == CD_W'(1)) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed checks of press detect, queueing, round-robin, cooldown,
// flush and reset, on a COOLDOWN=16 instance and a COOLDOWN=0 instance sharing inputs.
module tb_move_scheduler;
    logic       clk = 1'b0;
    logic       rst, game_enable, key_signal, key_player, move_ready;
    logic [3:0] key_cmd;
    logic       move_valid, move_player, v0, pl0;
    logic [3:0] move_cmd, c0;
    logic [2:0] pending0, pending1, pd0_0, pd1_0;
    logic [1:0] overflow, ov_0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    move_scheduler #(.DEPTH(4), .COOLDOWN(16), .CD_W(16)) dut (
        .clk(clk), .rst(rst), .game_enable(game_enable), .key_signal(key_signal),
        .key_cmd(key_cmd), .key_player(key_player), .move_ready(move_ready),
        .move_valid(move_valid), .move_cmd(move_cmd), .move_player(move_player),
        .pending0(pending0), .pending1(pending1), .overflow(overflow)
    );

    move_scheduler #(.DEPTH(4), .COOLDOWN(0), .CD_W(16)) dut0 (
        .clk(clk), .rst(rst), .game_enable(game_enable), .key_signal(key_signal),
        .key_cmd(key_cmd), .key_player(key_player), .move_ready(move_ready),
        .move_valid(v0), .move_cmd(c0), .move_player(pl0),
        .pending0(pd0_0), .pending1(pd1_0), .overflow(ov_0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; game_enable = 1'b1; key_signal = 1'b0; key_cmd = 4'd0;
        key_player = 1'b0; move_ready = 1'b0;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic press(input logic [3:0] cmd, input logic pl);
        key_signal = 1'b1; key_cmd = cmd; key_player = pl;
        tick;
        key_signal = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; game_enable = 1'b1; key_signal = 1'b0; key_cmd = 4'd0;
        key_player = 1'b0; move_ready = 1'b0;
        tick;
        tick;
        checks++; if ({move_valid, move_cmd, move_player} !== 6'd0) begin errors++; $display("FAIL reset_move got %b expected 0", {move_valid, move_cmd, move_player}); end
        checks++; if ({pending0, pending1, overflow} !== 8'd0) begin errors++; $display("FAIL reset_counts got %b expected 0", {pending0, pending1, overflow}); end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        int bad;
        do_reset;
        move_ready = 1'b1;
        key_signal = 1'b1; key_cmd = 4'd1; key_player = 1'b0;
        tick;
        checks++; if (pending0 !== 3'd1 || move_valid !== 1'b0) begin errors++; $display("FAIL lat_t1 got pend=%0d valid=%0d expected pend=1 valid=0", pending0, move_valid); end
        key_signal = 1'b0;
        tick;
        checks++; if ({move_valid, move_cmd, move_player} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL lat_t2 got %b expected 1_0001_0", {move_valid, move_cmd, move_player}); end
        checks++; if (pending0 !== 3'd0) begin errors++; $display("FAIL lat_pend_pop got %0d expected 0", pending0); end
        tick;
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle got %0d expected 0", move_valid); end
        key_signal = 1'b1; key_cmd = 4'd3; key_player = 1'b1;
        tick;
        key_signal = 1'b0;
        checks++; if (pending1 !== 3'd1) begin errors++; $display("FAIL cool_enqueue got %0d expected 1", pending1); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (move_valid !== 1'b0) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cooldown_gap got %0d valid cycles expected 0", bad); end
        checks++; if ({move_valid, move_cmd, move_player} !== {1'b1, 4'd3, 1'b1}) begin errors++; $display("FAIL after_cool got %b expected 1_0011_1", {move_valid, move_cmd, move_player}); end
    endtask

    task automatic test_hold;
        int issued, maxp;
        do_reset;
        move_ready = 1'b1;
        key_signal = 1'b1; key_cmd = 4'd2; key_player = 1'b1;
        issued = 0; maxp = 0;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (move_valid === 1'b1) issued++;
            if (int'(pending1) > maxp) maxp = int'(pending1);
        end
        key_signal = 1'b0;
        checks++; if (issued !== 1) begin errors++; $display("FAIL hold_issued got %0d expected 1", issued); end
        checks++; if (maxp !== 1) begin errors++; $display("FAIL hold_pending got %0d expected 1", maxp); end
    endtask

    task automatic test_stall;
        int n, bad;
        logic [3:0] got [8];
        do_reset;
        for (int k = 1; k <= 5; k++) press(4'(k), 1'b0);
        checks++; if (pending0 !== 3'd4 || overflow !== 2'b00) begin errors++; $display("FAIL stall_fill got pend=%0d ovf=%b expected pend=4 ovf=00", pending0, overflow); end
        press(4'd6, 1'b0);
        checks++; if (overflow !== 2'b01 || pending0 !== 3'd4) begin errors++; $display("FAIL stall_drop got ovf=%b pend=%0d expected ovf=01 pend=4", overflow, pending0); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({move_valid, move_cmd, move_player} !== {1'b1, 4'd1, 1'b0}) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles expected 0", bad); end
        move_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 120; i++) begin
            if (move_valid === 1'b1) begin
                if (n < 8) got[n] = move_cmd;
                if (move_player !== 1'b0) bad++;
                n++;
            end
            tick;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL stall_count got %0d expected 5", n); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (got[k] !== 4'(k + 1)) begin errors++; $display("FAIL stall_order[%0d] got %0d expected %0d", k, got[k], k + 1); end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_player got %0d bad expected 0", bad); end
    endtask

    task automatic test_round_robin;
        int n0, n16;
        logic [4:0] g0 [8];
        logic [4:0] g16 [8];
        logic [4:0] exp_seq [4];
        exp_seq = '{{4'd1, 1'b0}, {4'd5, 1'b1}, {4'd2, 1'b0}, {4'd6, 1'b1}};
        do_reset;
        press(4'd1, 1'b0);
        press(4'd2, 1'b0);
        press(4'd5, 1'b1);
        press(4'd6, 1'b1);
        move_ready = 1'b1;
        n0 = 0; n16 = 0;
        for (int i = 0; i < 100; i++) begin
            if (v0 === 1'b1) begin
                if (n0 < 8) g0[n0] = {c0, pl0};
                n0++;
            end
            if (move_valid === 1'b1) begin
                if (n16 < 8) g16[n16] = {move_cmd, move_player};
                n16++;
            end
            tick;
        end
        checks++; if (n0 !== 4 || n16 !== 4) begin errors++; $display("FAIL rr_count got cd0=%0d cd16=%0d expected 4 and 4", n0, n16); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (g0[k] !== exp_seq[k]) begin errors++; $display("FAIL rr_cd0[%0d] got cmd=%0d pl=%0d expected cmd=%0d pl=%0d", k, g0[k][4:1], g0[k][0], exp_seq[k][4:1], exp_seq[k][0]); end
            checks++; if (g16[k] !== exp_seq[k]) begin errors++; $display("FAIL rr_cd16[%0d] got cmd=%0d pl=%0d expected cmd=%0d pl=%0d", k, g16[k][4:1], g16[k][0], exp_seq[k][4:1], exp_seq[k][0]); end
        end
    endtask

    task automatic test_flush;
        do_reset;
        press(4'd1, 1'b0);
        press(4'd2, 1'b0);
        for (int k = 5; k <= 9; k++) press(4'(k), 1'b1);
        checks++; if ({move_valid, pending0, pending1, overflow} !== {1'b1, 3'd1, 3'd4, 2'b10}) begin errors++; $display("FAIL flush_pre got v=%0d p0=%0d p1=%0d ovf=%b expected v=1 p0=1 p1=4 ovf=10", move_valid, pending0, pending1, overflow); end
        game_enable = 1'b0;
        tick;
        game_enable = 1'b1;
        checks++; if ({move_valid, pending0, pending1, overflow} !== 9'd0) begin errors++; $display("FAIL flush_clear got v=%0d p0=%0d p1=%0d ovf=%b expected all 0", move_valid, pending0, pending1, overflow); end
        move_ready = 1'b1;
        press(4'd4, 1'b1);
        checks++; if ({move_valid, move_cmd, move_player} !== {1'b1, 4'd4, 1'b1}) begin errors++; $display("FAIL flush_after got %b expected 1_0100_1", {move_valid, move_cmd, move_player}); end
    endtask

    task automatic test_reset_in_cool;
        int bad;
        do_reset;
        move_ready = 1'b1;
        press(4'd2, 1'b0);
        tick;
        press(4'd3, 1'b1);
        checks++; if (move_valid !== 1'b0 || pending1 !== 3'd1) begin errors++; $display("FAIL cool_pre got v=%0d p1=%0d expected v=0 p1=1", move_valid, pending1); end
        key_signal = 1'b1; key_cmd = 4'd4; key_player = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if ({move_valid, move_cmd, move_player, pending0, pending1, overflow} !== 14'd0) begin errors++; $display("FAIL cool_reset got %b expected 0", {move_valid, move_cmd, move_player, pending0, pending1, overflow}); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (move_valid !== 1'b0 || pending0 !== 3'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL held_across_reset got %0d bad cycles expected 0", bad); end
        key_signal = 1'b0;
        tick;
        press(4'd4, 1'b0);
        checks++; if ({move_valid, move_cmd, move_player} !== {1'b1, 4'd4, 1'b0}) begin errors++; $display("FAIL repress got %b expected 1_0100_0", {move_valid, move_cmd, move_player}); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_hold;
        test_stall;
        test_round_robin;
        test_flush;
        test_reset_in_cool;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
